// File: rtl/mem_axi_master.sv
// rtl/mem_axi_master.sv - native single-beat memory bus to AXI4-Lite master bridge
// Optional response timeout/abort is enabled by defining MEM_AXI_TIMEOUT_EN.
module mem_axi_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_SHIFT     = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mem_valid,
    input  logic [ADDR_WIDTH-1:0]     mem_addr,
    input  logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH/8-1:0]   mem_wstrb,
    output logic                      mem_ready,
    output logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      mem_error,
    output logic [AXI_ADDR_WIDTH-1:0] m_araddr,
    output logic                      m_arvalid,
    input  logic                      m_arready,
    input  logic [DATA_WIDTH-1:0]     m_rdata,
    input  logic                      m_rvalid,
    output logic                      m_rready,
    output logic [AXI_ADDR_WIDTH-1:0] m_awaddr,
    output logic                      m_awvalid,
    input  logic                      m_awready,
    output logic [DATA_WIDTH-1:0]     m_wdata,
    output logic [DATA_WIDTH/8-1:0]   m_wstrb,
    output logic                      m_wvalid,
    input  logic                      m_wready,
    input  logic [1:0]                m_bresp,
    input  logic                      m_bvalid,
    output logic                      m_bready
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ADDR, S_RD_DATA, S_WR_REQ, S_WR_RESP, S_DONE
    } state_t;

    state_t                      state_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]       wdata_q;
    logic [STRB_WIDTH-1:0]       wstrb_q;
    logic [DATA_WIDTH-1:0]       rdata_q;
    logic                        ready_q, error_q;
    logic                        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
    logic                        aw_done_q, w_done_q;
    logic [AXI_ADDR_WIDTH-1:0]   addr_d;
    logic                        active;
    logic                        tmo_hit;

    assign addr_d = AXI_ADDR_WIDTH'(mem_addr >> ADDR_SHIFT);
    assign active = (state_q == S_RD_ADDR) || (state_q == S_RD_DATA) ||
                    (state_q == S_WR_REQ)  || (state_q == S_WR_RESP);

`ifdef MEM_AXI_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || !active) tmo_cnt_q <= '0;
        else                tmo_cnt_q <= tmo_cnt_q + 16'd1;
    end

    assign tmo_hit = active && (tmo_cnt_q == TMO_LAST);
`else
    logic unused_tmo;
    assign unused_tmo = ^TIMEOUT_CYCLES;
    assign tmo_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (tmo_hit) begin
            // Abandon the transaction; any late response is drained from IDLE.
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            rdata_q   <= '0;
            error_q   <= 1'b1;
            ready_q   <= 1'b1;
            state_q   <= S_DONE;
        end else begin
            ready_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (mem_valid) begin
                        addr_q    <= addr_d;
                        wdata_q   <= mem_wdata;
                        wstrb_q   <= mem_wstrb;
                        error_q   <= 1'b0;
                        rready_q  <= 1'b0;
                        bready_q  <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                        if (mem_wstrb == '0) begin
                            arvalid_q <= 1'b1;
                            state_q   <= S_RD_ADDR;
                        end else begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= S_WR_REQ;
                        end
                    end
                end
                S_RD_ADDR: begin
                    if (arvalid_q && m_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= S_RD_DATA;
                    end
                end
                S_RD_DATA: begin
                    if (rready_q && m_rvalid) begin
                        rdata_q  <= m_rdata;
                        error_q  <= 1'b0;
                        rready_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_WR_REQ: begin
                    if (awvalid_q && m_awready) begin
                        awvalid_q <= 1'b0;
                        aw_done_q <= 1'b1;
                    end
                    if (wvalid_q && m_wready) begin
                        wvalid_q <= 1'b0;
                        w_done_q <= 1'b1;
                    end
                    if (aw_done_q && w_done_q) begin
                        bready_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end
                end
                S_WR_RESP: begin
                    if (bready_q && m_bvalid) begin
                        error_q  <= (m_bresp != 2'b00);
                        rdata_q  <= '0;
                        bready_q <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
                S_DONE: begin
                    error_q <= 1'b0;
`ifdef MEM_AXI_TIMEOUT_EN
                    rready_q <= 1'b1;
                    bready_q <= 1'b1;
`endif
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_ready = ready_q;
    assign mem_rdata = rdata_q;
    assign mem_error = error_q;
    assign m_araddr  = addr_q;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;
    assign m_awaddr  = addr_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = wdata_q;
    assign m_wstrb   = wstrb_q;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
endmodule

// File: tb/tb_mem_axi_master.sv
// tb/tb_mem_axi_master.sv - self-checking bench for mem_axi_master with a stallable AXI-Lite slave model
module tb_mem_axi_master;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready, mem_error;
    logic [31:0] mem_rdata;
    logic [9:0]  m_araddr, m_awaddr;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;
    logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_rdata, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_bresp;

    always #5 clk = ~clk;

    mem_axi_master #(
        .ADDR_WIDTH(32), .AXI_ADDR_WIDTH(10), .DATA_WIDTH(32),
        .ADDR_SHIFT(2), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .mem_error(mem_error),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: each d_* is the number of stall cycles seen by the master on that channel.
    int          d_ar = 0, d_r = 0, d_aw = 0, d_w = 0, d_b = 0;
    logic [31:0] s_rdata = '0;
    logic [1:0]  s_bresp = '0;
    logic        late_rvalid = 1'b0;
    int          ar_cnt = 0, r_cnt = 0, aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_hs = 0;
    logic        ar_pend = 1'b0, aw_ok = 1'b0, w_ok = 1'b0;

    assign m_arready = m_arvalid && (ar_cnt >= d_ar);
    assign m_rvalid  = (ar_pend && (r_cnt >= d_r)) || late_rvalid;
    assign m_awready = m_awvalid && (aw_cnt >= d_aw);
    assign m_wready  = m_wvalid && (w_cnt >= d_w);
    assign m_bvalid  = aw_ok && w_ok && (b_cnt >= d_b);
    assign m_rdata   = s_rdata;
    assign m_bresp   = s_bresp;

    always @(posedge clk) begin
        if (rst) begin
            ar_cnt <= 0; r_cnt <= 0; aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0;
            ar_pend <= 1'b0; aw_ok <= 1'b0; w_ok <= 1'b0;
        end else begin
            ar_cnt <= (m_arvalid && !m_arready) ? ar_cnt + 1 : 0;
            r_cnt  <= (m_rready && ar_pend && !m_rvalid) ? r_cnt + 1 : 0;
            aw_cnt <= (m_awvalid && !m_awready) ? aw_cnt + 1 : 0;
            w_cnt  <= (m_wvalid && !m_wready) ? w_cnt + 1 : 0;
            b_cnt  <= (m_bready && aw_ok && w_ok && !m_bvalid) ? b_cnt + 1 : 0;
            if (m_arvalid && m_arready) begin
                ar_pend <= 1'b1;
                ar_hs   <= ar_hs + 1;
            end else if (m_rvalid && m_rready && ar_pend) begin
                ar_pend <= 1'b0;
            end
            if (m_awvalid && m_awready)     aw_ok <= 1'b1;
            else if (m_bvalid && m_bready)  aw_ok <= 1'b0;
            if (m_wvalid && m_wready)       w_ok <= 1'b1;
            else if (m_bvalid && m_bready)  w_ok <= 1'b0;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct {
        int          id;
        logic [9:0]  axi;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          awn;
        int          wn;
        int          start;
    } exp_t;

    exp_t exp_q[$];
    int   pulses = 0;

    // Scoreboard monitor: payload stability, valid durations and completion checks.
    initial begin
        int   aw_n = 0, w_n = 0;
        logic payload_bad = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (exp_q.size() > 0) begin
                    if (m_arvalid && (m_araddr !== exp_q[0].axi)) payload_bad = 1'b1;
                    if (m_awvalid) begin
                        aw_n++;
                        if (m_awaddr !== exp_q[0].axi) payload_bad = 1'b1;
                    end
                    if (m_wvalid) begin
                        w_n++;
                        if ({m_wdata, m_wstrb} !== {exp_q[0].wdata, exp_q[0].wstrb}) payload_bad = 1'b1;
                    end
                end
                if (mem_ready) begin
                    pulses++;
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_ready: actual=pulse required=none");
                    end else begin
                        e = exp_q.pop_front();
                        chk($sformatf("t%0d_rdata", e.id), 64'(mem_rdata), 64'(e.rdata));
                        chk($sformatf("t%0d_error", e.id), 64'(mem_error), 64'(e.err));
                        chk($sformatf("t%0d_latency", e.id), 64'(cyc - e.start), 64'(e.lat));
                        chk($sformatf("t%0d_aw_cycles", e.id), 64'(aw_n), 64'(e.awn));
                        chk($sformatf("t%0d_w_cycles", e.id), 64'(w_n), 64'(e.wn));
                        chk($sformatf("t%0d_payload_stable", e.id), 64'(payload_bad), 64'd0);
                    end
                    aw_n = 0;
                    w_n = 0;
                    payload_bad = 1'b0;
                end
            end
        end
    end

    task automatic do_req(input int id, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] wstrb, input logic [9:0] axi, input logic [31:0] rdata,
                          input logic err, input int lat, input int awn, input int wn);
        exp_t e;
        int   n;
        @(negedge clk);
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_wstrb = wstrb;
        mem_valid = 1'b1;
        e = '{id: id, axi: axi, wdata: wdata, wstrb: wstrb, rdata: rdata, err: err,
              lat: lat, awn: awn, wn: wn, start: cyc};
        exp_q.push_back(e);
        n = 0;
        while (!mem_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!mem_ready) begin
            total++;
            bad++;
            $display("FAIL t%0d_complete: actual=no mem_ready required=mem_ready", id);
            exp_q.delete();
        end
        mem_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] srdata;
        logic [1:0]  bresp;
        int          d_ar, d_r, d_aw, d_w, d_b;
        logic [9:0]  axi;
        logic [31:0] rdata;
        logic        err;
        int          lat, awn, wn;
    } vec_t;

    initial begin
        vec_t v[8];
        int   p0, h0, n;

        //        addr          wdata         strb  s_rdata       bresp ar r aw w b  axi     rdata         err lat awn wn
        v[0] = '{32'h0000_0010, 32'h0,        4'h0, 32'hDEAD_BEEF, 2'd0, 0, 0, 0, 0, 0, 10'h004, 32'hDEAD_BEEF, 1'b0, 3, 0, 0};
        v[1] = '{32'h0000_0020, 32'h1234_5678, 4'h3, 32'h0,       2'd0, 0, 0, 0, 2, 0, 10'h008, 32'h0,        1'b0, 6, 1, 3};
        v[2] = '{32'h0000_0044, 32'hA5A5_A5A5, 4'hF, 32'h0,       2'd2, 0, 0, 0, 0, 0, 10'h011, 32'h0,        1'b1, 4, 1, 1};
        v[3] = '{32'h0000_0FFC, 32'h0,        4'h0, 32'h0BAD_F00D, 2'd0, 1, 2, 0, 0, 0, 10'h3FF, 32'h0BAD_F00D, 1'b0, 6, 0, 0};
        v[4] = '{32'hFFFF_F004, 32'h0,        4'h0, 32'h55AA_00FF, 2'd0, 0, 0, 0, 0, 0, 10'h001, 32'h55AA_00FF, 1'b0, 3, 0, 0};
        v[5] = '{32'h0000_0100, 32'hCAFE_F00D, 4'h8, 32'h0,       2'd1, 0, 0, 2, 1, 1, 10'h040, 32'h0,        1'b1, 7, 3, 2};
        v[6] = '{32'h0000_003C, 32'h0F0F_0F0F, 4'h6, 32'h0,       2'd3, 0, 0, 2, 2, 0, 10'h00F, 32'h0,        1'b1, 6, 3, 3};
        v[7] = '{32'h0000_0008, 32'hFFFF_FFFF, 4'h0, 32'h1357_9BDF, 2'd0, 0, 3, 0, 0, 0, 10'h002, 32'h1357_9BDF, 1'b0, 6, 0, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 64'({mem_ready, mem_error, m_arvalid, m_rready, m_awvalid, m_wvalid,
                               m_bready, m_araddr, m_awaddr}), 64'd0);
        chk("reset_rdata", 64'(mem_rdata), 64'd0);
        chk("reset_wpayload", 64'({m_wdata, m_wstrb}), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            d_ar = v[i].d_ar; d_r = v[i].d_r; d_aw = v[i].d_aw; d_w = v[i].d_w; d_b = v[i].d_b;
            s_rdata = v[i].srdata;
            s_bresp = v[i].bresp;
            do_req(i, v[i].addr, v[i].wdata, v[i].wstrb, v[i].axi, v[i].rdata, v[i].err,
                   v[i].lat, v[i].awn, v[i].wn);
        end
        d_ar = 0; d_r = 0; d_aw = 0; d_w = 0; d_b = 0; s_bresp = 2'd0;

        // Back-to-back reads: second request presented in the cycle after mem_ready.
        p0 = pulses;
        h0 = ar_hs;
        s_rdata = 32'h0000_0001;
        do_req(10, 32'h0000_0200, 32'h0, 4'h0, 10'h080, 32'h0000_0001, 1'b0, 3, 0, 0);
        s_rdata = 32'h0000_0002;
        do_req(11, 32'h0000_0204, 32'h0, 4'h0, 10'h081, 32'h0000_0002, 1'b0, 3, 0, 0);
        repeat (4) @(negedge clk);
        chk("b2b_ar_count", 64'(ar_hs - h0), 64'd2);
        chk("b2b_pulses", 64'(pulses - p0), 64'd2);
`ifdef MEM_AXI_TIMEOUT_EN
        chk("idle_readies", 64'({m_rready, m_bready}), 64'h3);
`else
        chk("idle_readies", 64'({m_rready, m_bready}), 64'h0);
`endif

        // Reset while waiting in RD_DATA abandons the read.
        d_r = 1000;
        p0 = pulses;
        @(negedge clk);
        mem_addr  = 32'h0000_0030;
        mem_wstrb = 4'h0;
        mem_valid = 1'b1;
        n = 0;
        while (!m_rready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("reach_rd_data", 64'(m_rready), 64'd1);
        rst = 1'b1;
        mem_valid = 1'b0;
        @(negedge clk);
        chk("midrst_ctrl", 64'({mem_ready, mem_error, m_arvalid, m_rready, m_awvalid, m_wvalid,
                                m_bready, m_araddr, m_awaddr}), 64'd0);
        chk("midrst_rdata", 64'(mem_rdata), 64'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_pulse", 64'(pulses - p0), 64'd0);
        d_r = 0;
        s_rdata = 32'hFEED_0042;
        do_req(20, 32'h0000_0034, 32'h0, 4'h0, 10'h00D, 32'hFEED_0042, 1'b0, 3, 0, 0);

`ifdef MEM_AXI_TIMEOUT_EN
        // Slave never accepts AR: abort after TIMEOUT_CYCLES, then absorb a late R beat in IDLE.
        d_ar = 1000;
        s_rdata = 32'h7777_7777;
        do_req(30, 32'h0000_0040, 32'h0, 4'h0, 10'h010, 32'h0, 1'b1, 9, 0, 0);
        d_ar = 0;
        p0 = pulses;
        @(negedge clk);
        late_rvalid = 1'b1;
        chk("late_r_rready", 64'(m_rready), 64'd1);
        @(negedge clk);
        late_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("late_r_no_pulse", 64'(pulses - p0), 64'd0);
        s_rdata = 32'h0000_ABCD;
        do_req(31, 32'h0000_0050, 32'h0, 4'h0, 10'h014, 32'h0000_ABCD, 1'b0, 3, 0, 0);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
